// File: rtl/seven_segment_decoder.sv
// Decodes two active-low 7-segment digits back to a byte over valid/ready.
// Optional input synchronizer: define SEVEN_SEG_DEC_SYNC_EN.
module seven_segment_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] i_seg_lo,
   input  logic [6:0] i_seg_hi,
   output logic [7:0] o_byte,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_err,
   output logic       o_overrun
);

   localparam logic       ST_COUNT  = 1'b0;
   localparam logic       ST_HOLD   = 1'b1;
   localparam logic [13:0] BLANK    = '1;
   localparam logic [7:0] SETTLE_AT = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_SAT   = 8'(STABLE_CYCLES);

   logic [13:0] p, q, p_d;
   logic [7:0]  cnt;
   logic        state;
   logic [7:0]  last;
   logic        have_last;

   logic        settle, both_blank, legal, dup, load;
   logic [4:0]  dec_hi, dec_lo;
   logic [7:0]  value;

   function automatic logic [4:0] seg_dec(input logic [6:0] raw);
      logic [6:0] s;
      s = ~raw;
      case (s)
         7'h7E:   seg_dec = 5'h10;
         7'h30:   seg_dec = 5'h11;
         7'h6D:   seg_dec = 5'h12;
         7'h79:   seg_dec = 5'h13;
         7'h33:   seg_dec = 5'h14;
         7'h5B:   seg_dec = 5'h15;
         7'h5F:   seg_dec = 5'h16;
         7'h70:   seg_dec = 5'h17;
         7'h7F:   seg_dec = 5'h18;
         7'h7B:   seg_dec = 5'h19;
         7'h77:   seg_dec = 5'h1A;
         7'h1F:   seg_dec = 5'h1B;
         7'h4E:   seg_dec = 5'h1C;
         7'h3D:   seg_dec = 5'h1D;
         7'h4F:   seg_dec = 5'h1E;
         7'h47:   seg_dec = 5'h1F;
         default: seg_dec = 5'h00;
      endcase
   endfunction

`ifdef SEVEN_SEG_DEC_SYNC_EN
   logic [13:0] sync1, sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= BLANK;
         sync2 <= BLANK;
      end else begin
         sync1 <= {i_seg_hi, i_seg_lo};
         sync2 <= sync1;
      end
   end

   assign p_d = sync2;
`else
   assign p_d = {i_seg_hi, i_seg_lo};
`endif

   always_comb begin
      dec_hi     = seg_dec(p[13:7]);
      dec_lo     = seg_dec(p[6:0]);
      value      = {dec_hi[3:0], dec_lo[3:0]};
      settle     = (state == ST_COUNT) && (p == q) && (cnt == SETTLE_AT);
      both_blank = (p == BLANK);
      legal      = dec_hi[4] && dec_lo[4];
      dup        = have_last && (value == last);
      load       = settle && !both_blank && legal && !dup;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p     <= BLANK;
         q     <= BLANK;
         cnt   <= 8'd0;
         state <= ST_COUNT;
      end else begin
         p <= p_d;
         q <= p;
         if (p != q) begin
            cnt   <= 8'd0;
            state <= ST_COUNT;
         end else begin
            if (cnt != CNT_SAT)
               cnt <= cnt + 8'd1;
            if (settle)
               state <= ST_HOLD;
         end
      end
   end

   // A load on the handshake edge replaces the delivered value without overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         o_byte    <= 8'h00;
         o_valid   <= 1'b0;
         o_err     <= 1'b0;
         o_overrun <= 1'b0;
         last      <= 8'h00;
         have_last <= 1'b0;
      end else begin
         o_err     <= settle && !both_blank && !legal;
         o_overrun <= load && o_valid && !i_ready;
         if (load) begin
            o_byte    <= value;
            o_valid   <= 1'b1;
            last      <= value;
            have_last <= 1'b1;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule
